// File: rtl/mac_arbiter_if.sv
// Handshake bundle between two requesters, the shared MAC datapath and the arbiter.
// The slave modport is the arbiter side; master is the surrounding system.
interface mac_arbiter_if;
   logic               r0_valid, r0_ready;
   logic signed [15:0] r0_a, r0_b, r0_c, r0_d, r0_e;
   logic               r1_valid, r1_ready;
   logic signed [15:0] r1_a, r1_b, r1_c, r1_d, r1_e;
   logic               m_in_valid, m_in_ready;
   logic signed [15:0] m_a, m_b, m_c, m_d, m_e;
   logic               m_out_valid, m_out_ready;
   logic signed [31:0] m_y;
   logic               s0_valid, s0_ready;
   logic signed [31:0] s0_y;
   logic               s1_valid, s1_ready;
   logic signed [31:0] s1_y;
   logic [15:0]        grant_cnt0, grant_cnt1;
   logic               err;

   modport slave (
      input  r0_valid, r0_a, r0_b, r0_c, r0_d, r0_e,
      input  r1_valid, r1_a, r1_b, r1_c, r1_d, r1_e,
      input  m_in_ready, m_out_valid, m_y, s0_ready, s1_ready,
      output r0_ready, r1_ready, m_in_valid, m_a, m_b, m_c, m_d, m_e,
      output m_out_ready, s0_valid, s0_y, s1_valid, s1_y,
      output grant_cnt0, grant_cnt1, err
   );

   modport master (
      output r0_valid, r0_a, r0_b, r0_c, r0_d, r0_e,
      output r1_valid, r1_a, r1_b, r1_c, r1_d, r1_e,
      output m_in_ready, m_out_valid, m_y, s0_ready, s1_ready,
      input  r0_ready, r1_ready, m_in_valid, m_a, m_b, m_c, m_d, m_e,
      input  m_out_ready, s0_valid, s0_y, s1_valid, s1_y,
      input  grant_cnt0, grant_cnt1, err
   );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter for two requesters sharing one in-order MAC datapath.
// An ID FIFO remembers which requester each in-flight operation belongs to.
module mac_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic          tb_clk,
   input  logic          tb_rst,
   mac_arbiter_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [1:0]    r_rst_sync;
   logic          w_rst_n;
   logic          r_ids [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_last;
   logic [15:0]   r_cnt0, r_cnt1;
   logic          r_err;
   logic          w_full, w_empty, w_any, w_gnt, w_head, w_issue, w_ret;

   // Assert asynchronously, release on the second clock edge.
   always_ff @(posedge tb_clk or negedge tb_rst) begin
      if (!tb_rst) r_rst_sync <= 2'b00;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_any   = bus.r0_valid | bus.r1_valid;
   assign w_gnt   = (bus.r0_valid & bus.r1_valid) ? ~r_last : bus.r1_valid;
   assign w_head  = r_ids[r_rd_ptr];

   assign bus.m_in_valid = w_rst_n & w_any & ~w_full;
   assign bus.r0_ready   = w_rst_n & w_any & bus.m_in_ready & ~w_full & ~w_gnt;
   assign bus.r1_ready   = w_rst_n & w_any & bus.m_in_ready & ~w_full &  w_gnt;
   assign bus.m_a = w_gnt ? bus.r1_a : bus.r0_a;
   assign bus.m_b = w_gnt ? bus.r1_b : bus.r0_b;
   assign bus.m_c = w_gnt ? bus.r1_c : bus.r0_c;
   assign bus.m_d = w_gnt ? bus.r1_d : bus.r0_d;
   assign bus.m_e = w_gnt ? bus.r1_e : bus.r0_e;

   assign bus.s0_valid    = w_rst_n & bus.m_out_valid & ~w_empty & ~w_head;
   assign bus.s1_valid    = w_rst_n & bus.m_out_valid & ~w_empty &  w_head;
   assign bus.s0_y        = bus.m_y;
   assign bus.s1_y        = bus.m_y;
   assign bus.m_out_ready = w_rst_n & ~w_empty & (w_head ? bus.s1_ready : bus.s0_ready);

   assign bus.grant_cnt0 = r_cnt0;
   assign bus.grant_cnt1 = r_cnt1;
   assign bus.err        = r_err;

   assign w_issue = bus.m_in_valid & bus.m_in_ready;
   assign w_ret   = bus.m_out_valid & bus.m_out_ready;

   always_ff @(posedge tb_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_ids[i] <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= 1'b1;
         r_cnt0   <= '0;
         r_cnt1   <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_issue) begin
            r_ids[r_wr_ptr] <= w_gnt;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
            r_last          <= w_gnt;
            if (!w_gnt && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
            if ( w_gnt && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
         end
         if (w_ret) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_issue && !w_ret)      r_count <= r_count + CW'(1);
         else if (!w_issue && w_ret) r_count <= r_count - CW'(1);
         // A result with nothing outstanding is dropped and flagged.
         if (bus.m_out_valid && w_empty) r_err <= 1'b1;
      end
   end
endmodule
